router_pkt_tx: RTL and testbench

- Packet source for the router input port. Drives pkt_valid/data_in and obeys the router busy back-pressure.
- A host loads payload bytes into an internal buffer, then issues start with a destination.
- The block then emits header {len[5:0],addr[1:0]}, payload, and an XOR parity byte with pkt_valid low, followed by an inter-packet gap.
- Used as the stimulus/driver end of the router in system benches and as the packet front-end in integrated builds.

---
 rtl/router_pkt_tx_pkg.sv | 29 ++
 rtl/router_pkt_buf.sv | 45 ++++
 rtl/router_pkt_tx.sv | 178 +++++++++++++++++
 tb/tb_router_pkt_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/router_pkt_tx_pkg.sv
// Shared types and constants for the router packet source.
// Header layout, state encoding and header helper.
package router_pkt_tx_pkg;

  localparam int CNT_W = 6;
  localparam int ADDR_LSB = 0;
  localparam int LEN_LSB = 2;
  localparam logic [1:0] ILLEGAL_ADDR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_PAYLOAD,
    ST_PARITY,
    ST_GAP
  } state_t;

  function automatic logic [7:0] mk_header(
    input logic [CNT_W-1:0] len,
    input logic [1:0] addr
  );
    logic [7:0] h;
    h = '0;
    h[LEN_LSB +: CNT_W] = len;
    h[ADDR_LSB +: 2] = addr;
    return h;
  endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload byte buffer with fill count.
// Writes append at count; reads are combinational.
import router_pkt_tx_pkg::*;

module router_pkt_buf #(
  parameter int MAX_LEN = 63
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             clr,
  input  logic [CNT_W-1:0] rd_idx,
  output logic [7:0]       rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_LEN);

  logic [7:0] mem [MAX_LEN];
  logic       do_wr;

  assign full  = (count == LIMIT);
  assign do_wr = wr_en && !full;

  // fill count: cleared after a packet completes
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)    count <= '0;
    else if (clr)   count <= '0;
    else if (do_wr) count <= count + 1'b1;
  end

  // storage needs no reset; count gates validity
  always_ff @(posedge clock) begin
    if (do_wr) mem[count] <= wr_data;
  end

  // out-of-range index reads as zero
  always_comb begin
    rd_data = '0;
    if (rd_idx < LIMIT) rd_data = mem[rd_idx];
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet source for a router input port.
// Sends header, payload, parity, then an idle gap.
import router_pkt_tx_pkg::*;

module router_pkt_tx #(
  parameter int MAX_LEN = 63,
  parameter int IFG = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pay_wr,
  input  logic [7:0] pay_data,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic       inj_err,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       done,
  output logic       cfg_err,
  output logic       wr_drop
);

  localparam logic [7:0] GAP_LAST = 8'(IFG - 1);

  state_t state_q, state_d;

  logic [7:0]       data_q, data_d;
  logic [7:0]       par_q, par_d;
  logic             pv_q, pv_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [1:0]       addr_q, addr_d;
  logic             inj_q, inj_d;
  logic [7:0]       gap_q, gap_d;
  logic             done_q, done_d;
  logic             cerr_q, cerr_d;
  logic             drop_q, drop_d;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] rd_idx;
  logic [7:0]       rd_data;
  logic             full;
  logic             wr_ok;
  logic             buf_clr;
  logic             accept;

  assign accept    = !busy;
  assign tx_active = (state_q != ST_IDLE);
  assign wr_ok     = pay_wr && !tx_active
                  && !full && !start;
  assign rd_idx    = (state_q == ST_PAYLOAD)
                   ? idx_q + 1'b1 : '0;

  assign pkt_valid = pv_q;
  assign data_out  = data_q;
  assign done      = done_q;
  assign cfg_err   = cerr_q;
  assign wr_drop   = drop_q;

  router_pkt_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (wr_ok),
    .wr_data (pay_data),
    .clr     (buf_clr),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .count   (count),
    .full    (full)
  );

  // next state, presented byte and parity
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    par_d   = par_q;
    pv_d    = pv_q;
    len_d   = len_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    inj_d   = inj_q;
    gap_d   = gap_q;
    done_d  = 1'b0;
    cerr_d  = 1'b0;
    buf_clr = 1'b0;
    drop_d  = drop_q | (pay_wr & ~wr_ok);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (dest_addr == ILLEGAL_ADDR
              || count == '0) begin
            cerr_d = 1'b1;
          end else begin
            addr_d  = dest_addr;
            len_d   = count;
            inj_d   = inj_err;
            drop_d  = pay_wr;
            data_d  = mk_header(count, dest_addr);
            pv_d    = 1'b1;
            state_d = ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        if (accept) begin
          par_d   = data_q;
          idx_d   = '0;
          data_d  = rd_data;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          par_d = par_q ^ data_q;
          if (idx_q == len_q - 1'b1) begin
            data_d  = par_q ^ data_q
                    ^ {8{inj_q}};
            pv_d    = 1'b0;
            state_d = ST_PARITY;
          end else begin
            idx_d  = idx_q + 1'b1;
            data_d = rd_data;
          end
        end
      end
      ST_PARITY: begin
        if (accept) begin
          done_d  = 1'b1;
          buf_clr = 1'b1;
          data_d  = '0;
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      par_q   <= '0;
      pv_q    <= 1'b0;
      len_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      inj_q   <= 1'b0;
      gap_q   <= '0;
      done_q  <= 1'b0;
      cerr_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      par_q   <= par_d;
      pv_q    <= pv_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      inj_q   <= inj_d;
      gap_q   <= gap_d;
      done_q  <= done_d;
      cerr_q  <= cerr_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx.
// Hand-computed headers, payloads and parity.
module tb_router_pkt_tx;

  localparam int IFG = 3;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pay_wr;
  logic [7:0] pay_data;
  logic       start;
  logic [1:0] dest_addr;
  logic       inj_err;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_active;
  logic       done;
  logic       cfg_err;
  logic       wr_drop;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_pay [64];

  router_pkt_tx #(
    .MAX_LEN (63),
    .IFG     (IFG)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .pay_wr    (pay_wr),
    .pay_data  (pay_data),
    .start     (start),
    .dest_addr (dest_addr),
    .inj_err   (inj_err),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .tx_active (tx_active),
    .done      (done),
    .cfg_err   (cfg_err),
    .wr_drop   (wr_drop)
  );

  always #5 clock = ~clock;

  task automatic chk(
    input string tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h",
               tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic wr(input logic [7:0] b);
    pay_wr = 1'b1;
    pay_data = b;
    step();
    pay_wr = 1'b0;
  endtask

  task automatic go(
    input logic [1:0] a,
    input logic inj
  );
    start = 1'b1;
    dest_addr = a;
    inj_err = inj;
    step();
    start = 1'b0;
    inj_err = 1'b0;
  endtask

  task automatic load3();
    exp_pay[0] = 8'h11;
    exp_pay[1] = 8'h22;
    exp_pay[2] = 8'h33;
    wr(8'h11);
    wr(8'h22);
    wr(8'h33);
  endtask

  task automatic rx_pkt(
    input logic [7:0] hdr,
    input int n,
    input logic [7:0] par,
    input int stall_at,
    input int stall_n
  );
    chk("hdr", data_out, hdr);
    chk("hdr_pv", pkt_valid, 1);
    chk("hdr_act", tx_active, 1);
    step();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("pay%0d", i),
          data_out, exp_pay[i]);
      chk("pay_pv", pkt_valid, 1);
      if (i == stall_at) begin
        busy = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          step();
          chk("hold", data_out, exp_pay[i]);
          chk("hold_pv", pkt_valid, 1);
        end
        busy = 1'b0;
      end
      step();
    end
    chk("par", data_out, par);
    chk("par_pv", pkt_valid, 0);
    chk("par_done", done, 0);
    step();
    chk("done", done, 1);
    chk("gap_pv", pkt_valid, 0);
    chk("gap_data", data_out, 0);
    chk("gap_act", tx_active, 1);
    for (int g = 1; g < IFG; g++) begin
      step();
      chk("gap_act", tx_active, 1);
      chk("gap_done", done, 0);
    end
    step();
    chk("idle_act", tx_active, 0);
  endtask

  initial begin
    resetn = 1'b0;
    pay_wr = 1'b0;
    pay_data = '0;
    start = 1'b0;
    dest_addr = '0;
    inj_err = 1'b0;
    busy = 1'b0;
    step();
    chk("rst_pv", pkt_valid, 0);
    chk("rst_data", data_out, 0);
    chk("rst_act", tx_active, 0);
    chk("rst_done", done, 0);
    chk("rst_cerr", cfg_err, 0);
    chk("rst_drop", wr_drop, 0);
    resetn = 1'b1;
    step();

    // basic packet
    load3();
    go(2'd1, 1'b0);
    rx_pkt(8'h0D, 3, 8'h0D, -1, 0);

    // stall while 0x22 presented
    load3();
    go(2'd1, 1'b0);
    rx_pkt(8'h0D, 3, 8'h0D, 1, 2);

    // illegal destination then legal one
    exp_pay[0] = 8'h44;
    exp_pay[1] = 8'h55;
    wr(8'h44);
    wr(8'h55);
    go(2'd3, 1'b0);
    chk("cerr", cfg_err, 1);
    chk("cerr_pv", pkt_valid, 0);
    chk("cerr_act", tx_active, 0);
    step();
    chk("cerr_pulse", cfg_err, 0);
    go(2'd0, 1'b0);
    rx_pkt(8'h08, 2, 8'h19, -1, 0);

    // overfill and max-length packet
    for (int i = 0; i < 64; i++) begin
      exp_pay[i] = 8'hA5;
      wr(8'hA5);
    end
    chk("drop_set", wr_drop, 1);
    chk("cnt_full", dut.u_buf.count, 63);
    go(2'd2, 1'b0);
    chk("drop_clr", wr_drop, 0);
    rx_pkt(8'hFE, 63, 8'h5B, -1, 0);

    // injected parity error
    load3();
    go(2'd1, 1'b1);
    rx_pkt(8'h0D, 3, 8'hF2, -1, 0);

    // reset during second payload byte
    load3();
    go(2'd1, 1'b0);
    step();
    step();
    chk("pre_rst", data_out, 8'h22);
    resetn = 1'b0;
    #1;
    chk("arst_pv", pkt_valid, 0);
    chk("arst_data", data_out, 0);
    chk("arst_act", tx_active, 0);
    chk("arst_cnt", dut.u_buf.count, 0);
    step();
    resetn = 1'b1;
    step();
    load3();
    go(2'd1, 1'b0);
    rx_pkt(8'h0D, 3, 8'h0D, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
